// File: rtl/alu_operand_sequencer_if.sv
// Bus bundle between the TinyTapeout input pins / ALU and the operand sequencer.
// The master side drives the shared input bus, strobe, controls and the ALU result.
interface alu_operand_sequencer_if #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 2
);
    logic                 ena;
    logic [WIDTH-1:0]     data_in;
    logic                 load_strobe;
    logic                 abort;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [SEL_WIDTH-1:0] op_sel;
    logic                 op_valid;
    logic [WIDTH-1:0]     result_in;
    logic [WIDTH-1:0]     result_out;
    logic                 result_valid;
    logic                 busy;

    modport master (
        output ena, data_in, load_strobe, abort, result_in,
        input  op_a, op_b, op_sel, op_valid, result_out, result_valid, busy
    );

    modport slave (
        input  ena, data_in, load_strobe, abort, result_in,
        output op_a, op_b, op_sel, op_valid, result_out, result_valid, busy
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects operand A, operand B and the op select over one 8-bit bus in three
// strobed transfers, holds them for the ALU, then registers the ALU result.
module alu_operand_sequencer #(
    parameter int WIDTH       = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int EXEC_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_sequencer_if.slave  bus
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_B = 3'd1;
    localparam logic [2:0] ST_LOAD_S = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] CNT_LOAD  = 4'(EXEC_CYCLES - 1);

    logic [2:0]           state_r,        state_s;
    logic                 strobe_q_r,     strobe_q_s;
    logic [3:0]           cnt_r,          cnt_s;
    logic [WIDTH-1:0]     op_a_r,         op_a_s;
    logic [WIDTH-1:0]     op_b_r,         op_b_s;
    logic [SEL_WIDTH-1:0] op_sel_r,       op_sel_s;
    logic                 op_valid_r,     op_valid_s;
    logic [WIDTH-1:0]     result_out_r,   result_out_s;
    logic                 result_valid_r, result_valid_s;
    logic                 busy_r,         busy_s;
    logic                 edge_s;

    // Rising-edge detect; the history only advances while enabled so a strobe counts once
    always_comb begin
        edge_s     = bus.load_strobe & ~strobe_q_r & bus.ena;
        strobe_q_s = strobe_q_r;
        if (bus.ena) begin
            strobe_q_s = bus.load_strobe;
        end else begin
            strobe_q_s = strobe_q_r;
        end
    end

    // Next-state and datapath capture; abort overrides everything, ena=0 freezes all state
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        op_a_s         = op_a_r;
        op_b_s         = op_b_r;
        op_sel_s       = op_sel_r;
        result_out_s   = result_out_r;
        result_valid_s = result_valid_r;
        if (bus.abort) begin
            state_s        = ST_IDLE;
            result_valid_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (edge_s) begin
                        op_a_s  = bus.data_in;
                        state_s = ST_LOAD_B;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_LOAD_B: begin
                    if (edge_s) begin
                        op_b_s  = bus.data_in;
                        state_s = ST_LOAD_S;
                    end else begin
                        state_s = ST_LOAD_B;
                    end
                end
                ST_LOAD_S: begin
                    if (edge_s) begin
                        op_sel_s = bus.data_in[SEL_WIDTH-1:0];
                        cnt_s    = CNT_LOAD;
                        state_s  = ST_EXEC;
                    end else begin
                        state_s = ST_LOAD_S;
                    end
                end
                ST_EXEC: begin
                    // Strobes are ignored here: the operands must stay stable for the ALU
                    if (!bus.ena) begin
                        state_s = ST_EXEC;
                    end else if (cnt_r == 4'd0) begin
                        result_out_s   = bus.result_in;
                        result_valid_s = 1'b1;
                        state_s        = ST_DONE;
                    end else begin
                        cnt_s = cnt_r - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (edge_s) begin
                        result_valid_s = 1'b0;
                        op_a_s         = bus.data_in;
                        state_s        = ST_LOAD_B;
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        op_valid_s = (state_s == ST_EXEC);
        busy_s     = (state_s != ST_IDLE) && (state_s != ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            strobe_q_r     <= 1'b0;
            cnt_r          <= 4'd0;
            op_a_r         <= '0;
            op_b_r         <= '0;
            op_sel_r       <= '0;
            op_valid_r     <= 1'b0;
            result_out_r   <= '0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            strobe_q_r     <= strobe_q_s;
            cnt_r          <= cnt_s;
            op_a_r         <= op_a_s;
            op_b_r         <= op_b_s;
            op_sel_r       <= op_sel_s;
            op_valid_r     <= op_valid_s;
            result_out_r   <= result_out_s;
            result_valid_r <= result_valid_s;
            busy_r         <= busy_s;
        end
    end

    assign bus.op_a         = op_a_r;
    assign bus.op_b         = op_b_r;
    assign bus.op_sel       = op_sel_r;
    assign bus.op_valid     = op_valid_r;
    assign bus.result_out   = result_out_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_r;

endmodule
